// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one fixed-latency sprite ROM between N_REQ requesters.
// Grant and ROM address are combinational; a {valid, index} tag pipeline routes rom_q back to the winner.
module sprite_rom_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 2,
  parameter int ROM_LATENCY = 1
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic [IW-1:0] rr_q, rr_d, gi;
  logic any;
  logic [ROM_LATENCY-1:0] vld_q;
  logic [ROM_LATENCY-1:0][IW-1:0] idx_q;
  // Scan from rr_q upward with wrap; the first asserted request wins.
  always_comb begin
    gi = '0;
    any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && req[(int'(rr_q) + k) % N_REQ]) begin
        any = 1'b1;
        gi = IW'((int'(rr_q) + k) % N_REQ);
      end
    end
    any = any & en & reset_n;
  end
  assign gnt         = any ? N_REQ'(1) << gi : '0;
  assign rom_address = any ? req_addr[gi*ADDR_W +: ADDR_W] : '0;
  assign rr_d        = !any ? rr_q : (gi == IW'(N_REQ-1)) ? '0 : gi + 1'b1;
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q  <= '0;
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      rr_q     <= rr_d;
      vld_q[0] <= any;
      idx_q[0] <= gi;
      for (int s = 1; s < ROM_LATENCY; s++) begin
        vld_q[s] <= vld_q[s-1];
        idx_q[s] <= idx_q[s-1];
      end
    end
  end
  assign rsp_valid = vld_q[ROM_LATENCY-1] ? N_REQ'(1) << idx_q[ROM_LATENCY-1] : '0;
  assign rsp_data  = vld_q[ROM_LATENCY-1] ? rom_q : '0;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed plus random requests checked against a queue-based round-robin model.
module tb_sprite_rom_arbiter;
  localparam int N = 4, AW = 17, DW = 2, L = 2;
  logic vga_clk = 1'b0, reset_n = 1'b0, en = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0] gnt, rsp_valid;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] rom_q, rsp_data;
  logic [AW-1:0] ah [L];
  typedef struct { bit v; int i; logic [DW-1:0] d; } rsp_t;
  rsp_t pipe[$];
  int rr, last_g, n_chk, n_err;
  always #5 vga_clk = ~vga_clk;
  sprite_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(L)) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .en(en), .req(req), .req_addr(req_addr),
    .gnt(gnt), .rom_address(rom_address), .rom_q(rom_q),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data));
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return a[1:0] ^ a[5:4] ^ a[9:8] ^ a[16:15];
  endfunction
  // Behavioural ROM: word appears L clocks after its address.
  always @(posedge vga_clk) begin
    ah[0] <= rom_address;
    for (int s = 1; s < L; s++) ah[s] <= ah[s-1];
  end
  assign rom_q = rom_fn(ah[L-1]);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    rr = 0;
    last_g = -1;
    pipe.delete();
    repeat (L) pipe.push_back('{v: 1'b0, i: 0, d: '0});
  endtask
  // Called at a negedge; leaves the bench at the following negedge.
  task automatic cycle(input logic [N-1:0] r, input bit e, input logic [N*AW-1:0] a);
    int g;
    logic [AW-1:0] ea;
    req = r;
    en = e;
    req_addr = a;
    #1;
    g = -1;
    if (e) for (int k = 0; k < N; k++) if (g < 0 && r[(rr + k) % N]) g = (rr + k) % N;
    ea = g < 0 ? '0 : a[g*AW +: AW];
    chk("gnt", gnt, g < 0 ? 0 : 1 << g);
    chk("rom_address", rom_address, ea);
    chk("rsp_valid", rsp_valid, pipe[0].v ? 1 << pipe[0].i : 0);
    chk("rsp_data", rsp_data, pipe[0].v ? pipe[0].d : '0);
    last_g = g;
    @(posedge vga_clk);
    if (g >= 0) rr = (g + 1) % N;
    pipe.push_back('{v: g >= 0, i: g < 0 ? 0 : g, d: rom_fn(ea)});
    void'(pipe.pop_front());
    @(negedge vga_clk);
  endtask
  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_rom_address", rom_address, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;
    model_reset();
  endtask
  function automatic logic [N*AW-1:0] addrs(input int a0, a1, a2, a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction
  initial begin
    logic [N-1:0] rq;
    logic [N*AW-1:0] ra;
    @(negedge vga_clk);
    req = '1;
    en = 1'b1;
    pulse_reset();
    ra = addrs(0, 0, 'h155, 0);
    repeat (3) cycle(4'b0100, 1'b1, ra);
    repeat (L) cycle(4'b0000, 1'b1, ra);
    ra = addrs('h10, 'h20, 'h30, 'h40);
    repeat (8) cycle(4'b1111, 1'b1, ra);
    cycle(4'b0010, 1'b1, ra);
    repeat (3) cycle(4'b1011, 1'b1, ra);
    repeat (2) cycle(4'b1111, 1'b1, ra);
    repeat (2) cycle(4'b1111, 1'b0, ra);
    repeat (2) cycle(4'b1111, 1'b1, ra);
    cycle(4'b0011, 1'b1, ra);
    repeat (3) cycle(4'b0001, 1'b1, ra);
    cycle(4'b1111, 1'b1, ra);
    pulse_reset();
    cycle(4'b0110, 1'b1, ra);
    repeat (L) cycle(4'b0000, 1'b1, ra);
    rq = '0;
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < N; i++) begin
        if (rq[i] && last_g == i) begin
          rq[i] = 1'($urandom_range(0, 1));
          ra[i*AW +: AW] = AW'($urandom_range(0, (1 << AW) - 1));
        end else if (rq[i]) begin
          if ($urandom_range(0, 7) == 0) rq[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          rq[i] = 1'b1;
          ra[i*AW +: AW] = AW'($urandom_range(0, (1 << AW) - 1));
        end
      end
      cycle(rq, $urandom_range(0, 7) != 0, ra);
      if ($urandom_range(0, 149) == 0) begin
        pulse_reset();
        rq = '0;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
